// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and compare_result bit positions for the
// sequential ALU core and its multiplier.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int CMP_EQ = 0;
    localparam int CMP_GT = 1;
    localparam int CMP_LT = 2;

endpackage

// File: rtl/alu_seq_core_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH iterations; product is presented combinationally on the last one.
module alu_seq_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic               run_s;

    // One iteration: conditional add into the upper half, then shift right keeping the carry.
    always_comb begin
        addend_s  = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
        run_s     = (cnt_r != {CNT_W{1'b0}});
    end

    assign done    = (cnt_r == CNT_W'(1));
    assign product = acc_nxt_s;

    // Operand latch, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (start) begin
            mcand_r  <= mcand;
            mplier_r <= mplier;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= CNT_W'(WIDTH);
        end else if (run_s) begin
            acc_r    <= acc_nxt_s;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            acc_r    <= acc_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshakes and an iterative multiplier.
// Build option ALU_SEQ_SIGNED_CMP_EN makes GT/LT signed compares.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       compare_result,
    output logic             c_out,
    output logic             overflow,
    output logic             parity,
    output logic             busy
);

    function automatic logic calc_parity(input logic [2*WIDTH-1:0] v);
        calc_parity = ^v;
    endfunction

    state_t             state_r, state_nxt_s;
    logic               in_ready_s, accept_s, is_mul_s;
    logic               ld_alu_s, ld_mul_s, mul_start_s, mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0]   op_b_s, alu_res_s;
    logic [WIDTH:0]     sum_s;
    logic               carry_s, gt_s, lt_s, alu_cout_s, alu_ovf_s;
    logic [2:0]         alu_cmp_s;

    logic [WIDTH-1:0]   result_r, result_hi_r;
    logic [2:0]         cmp_r;
    logic               c_out_r, overflow_r, parity_r, out_valid_r, busy_r;

`ifdef ALU_SEQ_SIGNED_CMP_EN
    assign gt_s = ($signed(a) > $signed(b));
    assign lt_s = ($signed(a) < $signed(b));
`else
    assign gt_s = (a > b);
    assign lt_s = (a < b);
`endif

    assign is_mul_s    = (opcode == OP_MUL);
    assign accept_s    = in_valid && in_ready_s;
    assign ld_alu_s    = accept_s && !is_mul_s;
    assign mul_start_s = accept_s && is_mul_s;
    assign ld_mul_s    = (state_r == ST_MUL) && mul_done_s;

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .mcand   (a),
        .mplier  (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle datapath; SUB shares the adder as a + ~b + 1.
    always_comb begin
        op_b_s     = (opcode == OP_SUB) ? ~b : b;
        carry_s    = (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADD) ? c_in : 1'b0);
        sum_s      = {1'b0, a} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, carry_s};
        alu_res_s  = {WIDTH{1'b0}};
        alu_cmp_s  = 3'b000;
        alu_cout_s = 1'b0;
        alu_ovf_s  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_cout_s = sum_s[WIDTH];
                alu_ovf_s  = (a[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = a & b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_EQ:   alu_cmp_s[CMP_EQ] = (a == b);
            OP_GT:   alu_cmp_s[CMP_GT] = gt_s;
            OP_LT:   alu_cmp_s[CMP_LT] = lt_s;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and ready; DONE can accept a new op while its result drains.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nxt_s = is_mul_s ? ST_MUL : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DONE: begin
                in_ready_s = out_ready;
                if (in_valid && out_ready) begin
                    state_nxt_s = is_mul_s ? ST_MUL : ST_DONE;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                in_ready_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output registers, loaded on a single-cycle accept or on multiply completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            cmp_r       <= 3'b000;
            c_out_r     <= 1'b0;
            overflow_r  <= 1'b0;
            parity_r    <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_MUL);
            if (ld_alu_s) begin
                result_r    <= alu_res_s;
                result_hi_r <= {WIDTH{1'b0}};
                cmp_r       <= alu_cmp_s;
                c_out_r     <= alu_cout_s;
                overflow_r  <= alu_ovf_s;
                parity_r    <= calc_parity({{WIDTH{1'b0}}, alu_res_s});
            end else if (ld_mul_s) begin
                result_r    <= mul_prod_s[WIDTH-1:0];
                result_hi_r <= mul_prod_s[2*WIDTH-1:WIDTH];
                cmp_r       <= 3'b000;
                c_out_r     <= 1'b0;
                overflow_r  <= 1'b0;
                parity_r    <= calc_parity(mul_prod_s);
            end else begin
                result_r    <= result_r;
                result_hi_r <= result_hi_r;
                cmp_r       <= cmp_r;
                c_out_r     <= c_out_r;
                overflow_r  <= overflow_r;
                parity_r    <= parity_r;
            end
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign result         = result_r;
    assign result_hi      = result_hi_r;
    assign compare_result = cmp_r;
    assign c_out          = c_out_r;
    assign overflow       = overflow_r;
    assign parity         = parity_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised self-checking bench for alu_seq_core (WIDTH=16) against an
// arithmetic reference model; honours ALU_SEQ_SIGNED_CMP_EN for GT/LT.
module tb_alu_seq_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result, result_hi;
    logic [2:0]   compare_result;
    logic         c_out, overflow, parity, busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [2:0]   cmp;
        logic         cout;
        logic         ovf;
        logic         par;
    } exp_t;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .compare_result(compare_result),
        .c_out(c_out), .overflow(overflow), .parity(parity), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        exp_t   e;
        longint ux, uy, sx, sy, s, ss, smax, smin;
        logic   gt, lt;
        e    = '0;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
`ifdef ALU_SEQ_SIGNED_CMP_EN
        gt = (sx > sy);
        lt = (sx < sy);
`else
        gt = (ux > uy);
        lt = (ux < uy);
`endif
        case (op)
            3'd0: begin
                s = ux + uy + longint'(ci);
                e.res = s[W-1:0];
                e.cout = s[W];
                ss = sx + sy + longint'(ci);
                e.ovf = (ss > smax) || (ss < smin);
            end
            3'd1: begin
                s = ux - uy;
                e.res = s[W-1:0];
                e.cout = (ux >= uy);
                ss = sx - sy;
                e.ovf = (ss > smax) || (ss < smin);
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x ^ y;
            3'd4: e.cmp = (x == y) ? 3'b001 : 3'b000;
            3'd5: e.cmp = gt ? 3'b010 : 3'b000;
            3'd6: e.cmp = lt ? 3'b100 : 3'b000;
            default: begin
                s = ux * uy;
                e.res = s[W-1:0];
                e.hi = s[2*W-1:W];
            end
        endcase
        e.par = ($countones({e.hi, e.res}) % 2) == 1;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.res = result; o.hi = result_hi; o.cmp = compare_result;
        o.cout = c_out; o.ovf = overflow; o.par = parity;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, check latency and result, optionally stall, then drain.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int hold);
        exp_t e;
        int n, nb;
        e = model(op, x, y, ci);
        out_ready = 1'b0;
        opcode = op; a = x; b = y; c_in = ci; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        check("accept_wait", n, 0);
        step();
        in_valid = 1'b0;
        if (op == 3'd7) begin
            n = 0; nb = 0;
            while (!out_valid && n < 4 * W) begin
                if (busy) nb++;
                step();
                n++;
            end
            check("mul_latency", n, W);
            check("mul_busy_cycles", nb, W);
        end else begin
            check("alu_latency", out_valid, 1);
        end
        check("result", result, e.res);
        check("result_hi", result_hi, e.hi);
        check("compare_result", compare_result, e.cmp);
        check("c_out", c_out, e.cout);
        check("overflow", overflow, e.ovf);
        check("parity", parity, e.par);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_outputs", {out_valid, observed()}, {1'b1, e});
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("back_to_idle", out_valid, 0);
    endtask

    initial begin
        exp_t q[$];
        exp_t ge, xe;
        int n, stale;
        logic [2:0] op;

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_outputs", observed(), '0);
        check("rst_flags", {out_valid, busy, in_ready}, 3'b001);
        rst_n = 1'b1;
        step();

        run_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(3'd1, 16'h0003, 16'h0005, 1'b0, 5);
        run_op(3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(3'd6, 16'h8000, 16'h0001, 1'b0, 0);
        run_op(3'd5, 16'h8000, 16'h0001, 1'b0, 0);
        run_op(3'd0, 16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(3'd1, 16'h8000, 16'h0001, 1'b1, 1);
        run_op(3'd4, 16'h1234, 16'h1234, 1'b0, 0);

        // Back-to-back XOR then EQ.
        out_ready = 1'b1;
        opcode = 3'd3; a = 16'h1234; b = 16'h0F0F; in_valid = 1'b1;
        step();
        opcode = 3'd4; a = 16'h5A5A; b = 16'h5A5A;
        check("b2b_valid1", out_valid, 1);
        check("b2b_xor", observed(), model(3'd3, 16'h1234, 16'h0F0F, 1'b0));
        step();
        in_valid = 1'b0;
        check("b2b_valid2", out_valid, 1);
        check("b2b_eq", observed(), model(3'd4, 16'h5A5A, 16'h5A5A, 1'b0));
        step();
        check("b2b_drained", out_valid, 0);
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        opcode = 3'd7; a = 16'hABCD; b = 16'h1357; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        check("abort_outputs", observed(), '0);
        check("abort_flags", {out_valid, busy, in_ready}, 3'b001);
        rst_n = 1'b1;
        stale = 0;
        repeat (W + 5) begin
            step();
            if (out_valid || busy) stale++;
        end
        check("abort_no_stale", stale, 0);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a = W'($urandom);
            run_op(op, a, ($urandom_range(0, 5) == 0) ? a : W'($urandom),
                   1'($urandom), $urandom_range(0, 2));
        end

        // Streaming with random valid/ready on both sides against a FIFO of expectations.
        xe = '1;
        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 6));
            opcode = op;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            c_in = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                ge = (q.size() > 0) ? q.pop_front() : xe;
                check("stream", observed(), ge);
            end
            if (in_valid && in_ready) q.push_back(model(opcode, a, b, c_in));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            #1;
            if (out_valid) begin
                ge = q.pop_front();
                check("drain", observed(), ge);
            end
            step();
            n++;
        end
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
